seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 20 ++
 rtl/seg_scan_driver_bcd_to_seg7.sv | 27 ++
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are active-high, with bit0 = a through bit6 = g.
package seg_scan_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder with an active-high output.
// Codes 10-15 are not decimal digits, so they are shown as a dash.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner that latches a full frame of digits at each index-0 slot.
// Defining SEG_SCAN_DRIVER_LZB_EN enables leading-zero blanking.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                          seg_scan_driver_clk,
    input  logic                          seg_scan_driver_rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] seg_scan_driver_digits,
    input  logic [NUM_DIGITS-1:0]         seg_scan_driver_digit_en,
    input  logic [NUM_DIGITS-1:0]         seg_scan_driver_dp,
    output logic [6:0]                    seg_scan_driver_seg,
    output logic                          seg_scan_driver_dp_out,
    output logic [NUM_DIGITS-1:0]         seg_scan_driver_an,
    output logic                          seg_scan_driver_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV + 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = INV ? '1 : '0;
    localparam logic [6:0]            SEG_IDLE = INV ? ~SEG_OFF : SEG_OFF;
    localparam logic                  DP_OFF   = INV;

    logic [PRE_W-1:0]              prescale_q, prescale_d;
    logic [IDX_W-1:0]              index_q, index_d;
    logic                          frameLoad_q, frameLoad_d;
    logic [DIGIT_W*NUM_DIGITS-1:0] shDigits_q;
    logic [NUM_DIGITS-1:0]         shEn_q, shDp_q;

    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [6:0]                    seg_q, seg_d;
    logic                          dpOut_q, dpOut_d;
    logic                          tick_q, tick_d;

    logic                          terminal;
    logic [DIGIT_W*NUM_DIGITS-1:0] curDigits;
    logic [NUM_DIGITS-1:0]         curEn, curDp, blankMask;
    logic [DIGIT_W-1:0]            selVal;
    logic                          selEn, selDp, selBlank;
    logic [6:0]                    patHigh;
    logic                          anOn, segOn, dpOn;
    logic [NUM_DIGITS-1:0]         anHigh;
    logic [6:0]                    segHigh;

    // On the load cycle the shadow is still stale, so the live inputs being latched are shown instead.
    always_comb begin
        curDigits = frameLoad_q ? seg_scan_driver_digits   : shDigits_q;
        curEn     = frameLoad_q ? seg_scan_driver_digit_en : shEn_q;
        curDp     = frameLoad_q ? seg_scan_driver_dp       : shDp_q;
    end

    always_comb begin
        terminal    = (prescale_q == PRE_LAST);
        prescale_d  = terminal ? '0 : prescale_q + 1'b1;
        index_d     = index_q;
        frameLoad_d = 1'b0;
        if (terminal) begin
            if (index_q == IDX_LAST) begin
                index_d     = '0;
                frameLoad_d = 1'b1;
            end else begin
                index_d = index_q + 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_DRIVER_LZB_EN
    logic zeroAbove;

    // A digit is a leading zero while every more significant digit is zero or disabled.
    always_comb begin
        blankMask = '0;
        zeroAbove = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            blankMask[i] = zeroAbove && (curDigits[i*DIGIT_W +: DIGIT_W] == '0);
            zeroAbove    = zeroAbove && ((curDigits[i*DIGIT_W +: DIGIT_W] == '0) || !curEn[i]);
        end
    end
`else
    assign blankMask = '0;
`endif

    always_comb begin
        selVal   = '0;
        selEn    = 1'b0;
        selDp    = 1'b0;
        selBlank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == IDX_W'(i)) begin
                selVal   = curDigits[i*DIGIT_W +: DIGIT_W];
                selEn    = curEn[i];
                selDp    = curDp[i];
                selBlank = blankMask[i];
            end
        end
    end

    bcd_to_seg7 u_decode (
        .bcd_i (selVal),
        .seg_o (patHigh)
    );

    // A blanked digit keeps its anode on only so that a requested decimal point stays visible.
    always_comb begin
        anOn    = selEn && (!selBlank || selDp);
        segOn   = selEn && !selBlank;
        dpOn    = selEn && selDp;
        anHigh  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anHigh[i] = anOn && (index_q == IDX_W'(i));
        end
        segHigh = segOn ? patHigh : SEG_OFF;
        an_d    = INV ? ~anHigh  : anHigh;
        seg_d   = INV ? ~segHigh : segHigh;
        dpOut_d = INV ? ~dpOn    : dpOn;
        tick_d  = terminal;
    end

    always_ff @(posedge seg_scan_driver_clk) begin
        if (seg_scan_driver_rst) begin
            prescale_q  <= '0;
            index_q     <= '0;
            frameLoad_q <= 1'b1;
            shDigits_q  <= '0;
            shEn_q      <= '0;
            shDp_q      <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_IDLE;
            dpOut_q     <= DP_OFF;
            tick_q      <= 1'b0;
        end else begin
            prescale_q  <= prescale_d;
            index_q     <= index_d;
            frameLoad_q <= frameLoad_d;
            if (frameLoad_q) begin
                shDigits_q <= seg_scan_driver_digits;
                shEn_q     <= seg_scan_driver_digit_en;
                shDp_q     <= seg_scan_driver_dp;
            end
            an_q        <= an_d;
            seg_q       <= seg_d;
            dpOut_q     <= dpOut_d;
            tick_q      <= tick_d;
        end
    end

    assign seg_scan_driver_an     = an_q;
    assign seg_scan_driver_seg    = seg_q;
    assign seg_scan_driver_dp_out = dpOut_q;
    assign seg_scan_driver_tick   = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench for seg_scan_driver with 4 digits, a 4-cycle slot and active-low outputs.
// The expected display for each frame is queued from the digits that frame should latch.
module tb_seg_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  digitEn = '0;
    logic [3:0]  dpReq = '0;
    logic [6:0]  seg;
    logic        dpOut;
    logic [3:0]  an;
    logic        tick;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .ACTIVE_LOW  (1)
    ) dut (
        .seg_scan_driver_clk      (clk),
        .seg_scan_driver_rst      (rst),
        .seg_scan_driver_digits   (digits),
        .seg_scan_driver_digit_en (digitEn),
        .seg_scan_driver_dp       (dpReq),
        .seg_scan_driver_seg      (seg),
        .seg_scan_driver_dp_out   (dpOut),
        .seg_scan_driver_an       (an),
        .seg_scan_driver_tick     (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segPattern(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp);
        digits  = d;
        digitEn = en;
        dpReq   = dp;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the first n cycles of the display a frame of (d, en, dp) should produce.
    task automatic pushFrame(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp, input int n);
        logic [3:0] blank;
        logic       zeroAbove;
        logic [3:0] v;
        exp_t       e;
        blank     = '0;
        zeroAbove = 1'b1;
`ifdef SEG_SCAN_DRIVER_LZB_EN
        for (int i = 3; i >= 1; i--) begin
            v         = d[i*4 +: 4];
            blank[i]  = zeroAbove && (v == 4'd0);
            zeroAbove = zeroAbove && ((v == 4'd0) || !en[i]);
        end
`endif
        for (int c = 0; c < n; c++) begin
            int s;
            s      = c / DIV;
            v      = d[s*4 +: 4];
            e.an   = (en[s] && (!blank[s] || dp[s])) ? ~(4'b0001 << s) : 4'hF;
            e.seg  = (en[s] && !blank[s]) ? ~segPattern(v) : 7'h7F;
            e.dp   = (en[s] && dp[s]) ? 1'b0 : 1'b1;
            e.tick = ((c % DIV) == DIV - 1);
            sb.push_back(e);
        end
    endtask

    task automatic runCycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard: queue empty at cycle %0d, observed an=%h expected entry present", k, an);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("an[c%0d]", k),   16'(an),    16'(e.an));
                checkOutput($sformatf("seg[c%0d]", k),  16'(seg),   16'(e.seg));
                checkOutput($sformatf("dp[c%0d]", k),   16'(dpOut), 16'(e.dp));
                checkOutput($sformatf("tick[c%0d]", k), 16'(tick),  16'(e.tick));
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_an"},   16'(an),    16'h000F);
        checkOutput({tag, "_seg"},  16'(seg),   16'h007F);
        checkOutput({tag, "_dp"},   16'(dpOut), 16'h0001);
        checkOutput({tag, "_tick"}, 16'(tick),  16'h0000);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(16'h1234, 4'hF, 4'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");

        $display("[TB] free-running scan of 1234");
        rst = 1'b0;
        pushFrame(16'h1234, 4'hF, 4'h0, 16);
        runCycles(16);

        $display("[TB] anti-tearing: inputs change during slot 2");
        pushFrame(16'h1234, 4'hF, 4'h0, 16);
        runCycles(9);
        applyStimulus(16'h9999, 4'hF, 4'h0);
        runCycles(7);
        pushFrame(16'h9999, 4'hF, 4'h0, 16);
        runCycles(16);

        $display("[TB] dash, disabled slot 2, dp on digit 1");
        applyStimulus(16'h12C4, 4'b1011, 4'b0010);
        pushFrame(16'h12C4, 4'b1011, 4'b0010, 16);
        runCycles(16);

        $display("[TB] reset during slot 2");
        applyStimulus(16'h1234, 4'hF, 4'h0);
        pushFrame(16'h1234, 4'hF, 4'h0, 9);
        runCycles(9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("midreset");
        rst = 1'b0;
        pushFrame(16'h1234, 4'hF, 4'h0, 16);
        runCycles(16);

        $display("[TB] leading zeros 0050");
        applyStimulus(16'h0050, 4'hF, 4'h0);
        pushFrame(16'h0050, 4'hF, 4'h0, 16);
        runCycles(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
